// File: rtl/wts_noise_pkg.sv
// Shared constants and the LFSR step function for the wave table noise generators.
// Both periods use a 15-bit right-shift register with feedback into the top bit.
package wts_noise_pkg;

    localparam int LFSR_W = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;

    localparam int LONG_TAP  = 1;
    localparam int SHORT_TAP = 6;

    typedef enum logic {
        NOISE_MODE_LONG  = 1'b0,
        NOISE_MODE_SHORT = 1'b1
    } noise_mode_e;

    // Shift right by one; the new bit14 is bit0 xor the mode-selected tap.
    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] state,
        input noise_mode_e       mode
    );
        logic feedback;
        feedback = state[0] ^ ((mode == NOISE_MODE_SHORT) ? state[SHORT_TAP] : state[LONG_TAP]);
        return {feedback, state[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/wts_noise_lfsr.sv
// One noise generator: a reload divider clocked by the CPU timing slot tick,
// stepping a 15-bit LFSR whose period is selected by mode; reseed restarts both.
import wts_noise_pkg::*;

module wts_noise_lfsr #(
    parameter int FREQ_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              reseed,
    input  logic              mode,
    input  logic [FREQ_W-1:0] frequency,
    output logic              noise_bit
);

    logic [LFSR_W-1:0] lfsr;
    logic [FREQ_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr  <= LFSR_SEED;
            count <= '0;
        end else if (reseed) begin
            lfsr  <= LFSR_SEED;
            count <= frequency;
        end else if (tick) begin
            // The reload reads frequency only here, so a new value waits for the next step.
            if (count == '0) begin
                count <= frequency;
                lfsr  <= lfsr_step(lfsr, noise_mode_e'(mode));
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign noise_bit = lfsr[0];

endmodule

// File: rtl/wts_noise_generator_nch.sv
// NUM_NOISE independent noise generators plus a slot-multiplexed router that
// registers NUM_OUT noise bits for whichever wave channel is currently active.
import wts_noise_pkg::*;

module wts_noise_generator_nch #(
    parameter  int NUM_NOISE = 4,
    parameter  int NUM_CH    = 5,
    parameter  int NUM_OUT   = 2,
    parameter  int FREQ_W    = 5,
    parameter  int ACTIVE_W  = 3,
    localparam int SEL_W     = ($clog2(NUM_NOISE) < 1) ? 1 : $clog2(NUM_NOISE)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ACTIVE_W-1:0]               active,
    input  logic [NUM_CH*NUM_OUT-1:0]         reg_noise_enable,
    input  logic [NUM_CH*NUM_OUT*SEL_W-1:0]   reg_noise_sel,
    input  logic [NUM_NOISE*FREQ_W-1:0]       reg_noise_frequency,
    input  logic [NUM_NOISE-1:0]              reg_noise_mode,
    input  logic [NUM_NOISE-1:0]              reg_noise_reseed,
    output logic [NUM_OUT-1:0]                noise,
    output logic [NUM_NOISE-1:0]              noise_raw
);

    localparam int PAD_W = 1 << SEL_W;

    logic              tick;
    logic [PAD_W-1:0]  gen_pad;
    logic [SEL_W-1:0]  sel;
    logic [NUM_OUT-1:0] noise_next;

    assign tick = (active == ACTIVE_W'(NUM_CH));

    for (genvar g = 0; g < NUM_NOISE; g++) begin : g_gen
        wts_noise_lfsr #(
            .FREQ_W (FREQ_W)
        ) u_lfsr (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .reseed    (reg_noise_reseed[g]),
            .mode      (reg_noise_mode[g]),
            .frequency (reg_noise_frequency[g*FREQ_W +: FREQ_W]),
            .noise_bit (noise_raw[g])
        );
    end

    // Unpopulated select codes read as 1, so a select past NUM_NOISE yields a silent-high bit.
    always_comb begin
        gen_pad                = '1;
        gen_pad[NUM_NOISE-1:0] = noise_raw;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        noise_next = noise;
        sel        = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (active == ACTIVE_W'(c)) begin
                for (int o = 0; o < NUM_OUT; o++) begin
                    sel           = reg_noise_sel[(c*NUM_OUT + o)*SEL_W +: SEL_W];
                    noise_next[o] = reg_noise_enable[c*NUM_OUT + o] ? gen_pad[sel] : 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            noise <= '1;
        end else begin
            noise <= noise_next;
        end
    end

endmodule

// File: tb/tb_wts_noise_generator_nch.sv
// Directed bench for wts_noise_generator_nch with three generators, so select 3 is out of range.
// Stimulus queues expected outputs per edge; a negedge monitor pops and compares them.
module tb_wts_noise_generator_nch;

    localparam int NN = 3;
    localparam int NC = 5;
    localparam int NO = 2;
    localparam int FW = 5;
    localparam int AW = 3;
    localparam int SW = 2;

    // bit k = LFSR bit0 after k steps from the seed.
    // Long mode: states 0x0001,0x4000..0x0002,0x4001,0x6000..0x0006,0x4003,0x2001,0x5000.
    localparam logic [31:0] LONG_TBL  = 32'h6000_8001;
    // Short mode: ...,0x0040,0x4020,0x2010,..,0x0201,0x4100,..,0x4820,..,0x0482,0x0241.
    localparam logic [31:0] SHORT_TBL = 32'h0100_8001;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [AW-1:0]           active;
    logic [NC*NO-1:0]        reg_noise_enable;
    logic [NC*NO*SW-1:0]     reg_noise_sel;
    logic [NN*FW-1:0]        reg_noise_frequency;
    logic [NN-1:0]           reg_noise_mode;
    logic [NN-1:0]           reg_noise_reseed;
    logic [NO-1:0]           noise;
    logic [NN-1:0]           noise_raw;

    typedef struct {
        string         name;
        logic [NO-1:0] noise;
        logic          chk_noise;
        logic [NN-1:0] raw;
        logic [NN-1:0] raw_mask;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    wts_noise_generator_nch #(
        .NUM_NOISE (NN),
        .NUM_CH    (NC),
        .NUM_OUT   (NO),
        .FREQ_W    (FW),
        .ACTIVE_W  (AW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .active              (active),
        .reg_noise_enable    (reg_noise_enable),
        .reg_noise_sel       (reg_noise_sel),
        .reg_noise_frequency (reg_noise_frequency),
        .reg_noise_mode      (reg_noise_mode),
        .reg_noise_reseed    (reg_noise_reseed),
        .noise               (noise),
        .noise_raw           (noise_raw)
    );

    always #5 clk = ~clk;

    function automatic logic tbl(input logic [31:0] t, input int k);
        return t[k[4:0]];
    endfunction

    // Advance one rising edge with the current inputs and queue what the outputs must be after it.
    task automatic step(input string name, input logic [NO-1:0] en, input logic cn,
                        input logic [NN-1:0] er, input logic [NN-1:0] rm);
        exp_t e;
        @(posedge clk);
        #1;
        e.name      = name;
        e.noise     = en;
        e.chk_noise = cn;
        e.raw       = er;
        e.raw_mask  = rm;
        q.push_back(e);
    endtask

    task automatic set_route(input int c, input int o, input logic en, input logic [SW-1:0] s);
        reg_noise_enable[c*NO + o]        = en;
        reg_noise_sel[(c*NO + o)*SW +: SW] = s;
    endtask

    task automatic set_freq(input int g, input logic [FW-1:0] f);
        reg_noise_frequency[g*FW +: FW] = f;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk_noise) begin
                n_checks++;
                if (noise === e.noise) n_pass++;
                else $display("FAIL %s noise: got %b want %b", e.name, noise, e.noise);
            end
            if (e.raw_mask != '0) begin
                n_checks++;
                if ((noise_raw & e.raw_mask) === (e.raw & e.raw_mask)) n_pass++;
                else $display("FAIL %s noise_raw (mask %b): got %b want %b",
                              e.name, e.raw_mask, noise_raw, e.raw);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [NN-1:0] er;
        int            g1;

        reset               = 1'b1;
        active              = 3'd7;
        reg_noise_enable    = '0;
        reg_noise_sel       = '0;
        reg_noise_frequency = '0;
        reg_noise_mode      = '0;
        reg_noise_reseed    = '0;
        set_freq(0, 5'd0);
        set_freq(1, 5'd3);
        set_freq(2, 5'd1);

        step("reset0", 2'b11, 1'b1, 3'b111, 3'b111);
        step("reset1", 2'b11, 1'b1, 3'b111, 3'b111);
        reset = 1'b0;
        step("idle", 2'b11, 1'b1, 3'b111, 3'b111);

        // Ticks every 6th cycle; gen0 steps every tick, gen1 every 4th (freq 3 -> 0 after tick 10), gen2 every 2nd.
        for (int t = 1; t <= 31; t++) begin
            if (t == 11) set_freq(1, 5'd0);
            g1 = (t <= 12) ? (t - 1) / 4 + 1 : t - 9;
            er = {tbl(LONG_TBL, (t + 1) / 2), tbl(LONG_TBL, g1), tbl(LONG_TBL, t)};
            active = 3'd5;
            step($sformatf("A tick %0d", t), 2'b11, 1'b1, er, 3'b111);
            for (int k = 0; k < 5; k++) begin
                active = (k % 2 == 0) ? 3'd6 : 3'd7;
                step($sformatf("A gap %0d.%0d", t, k), 2'b11, 1'b1, er, 3'b111);
            end
        end

        // Routing: all generators read 0 here (gen0 s31, gen1 s22, gen2 s16).
        set_route(2, 0, 1'b1, 2'd1);
        set_route(2, 1, 1'b0, 2'd0);
        active = 3'd2;
        step("route ch2", 2'b10, 1'b1, 3'b000, 3'b111);
        active = 3'd5;
        step("hold tick", 2'b10, 1'b1, 3'b000, 3'b111);
        active = 3'd6;
        step("hold 6", 2'b10, 1'b1, 3'b000, 3'b111);
        active = 3'd7;
        step("hold 7", 2'b10, 1'b1, 3'b000, 3'b111);
        set_route(3, 0, 1'b1, 2'd3);
        set_route(3, 1, 1'b0, 2'd0);
        active = 3'd3;
        step("sel out of range", 2'b11, 1'b1, 3'b000, 3'b111);
        set_route(0, 0, 1'b0, 2'd0);
        set_route(0, 1, 1'b1, 2'd2);
        active = 3'd0;
        step("route ch0", 2'b01, 1'b1, 3'b000, 3'b111);
        active = 3'd1;
        step("route ch1 off", 2'b11, 1'b1, 3'b000, 3'b111);

        // Reseed colliding with a due step: reload counter to freq0, no step.
        set_freq(0, 5'd1);
        active           = 3'd7;
        reg_noise_reseed = 3'b001;
        step("reseed0", 2'b11, 1'b1, 3'b001, 3'b001);
        reg_noise_reseed = 3'b000;
        active           = 3'd5;
        step("count to 0", 2'b11, 1'b1, 3'b001, 3'b001);
        reg_noise_reseed = 3'b001;
        step("reseed vs tick", 2'b11, 1'b1, 3'b001, 3'b001);
        reg_noise_reseed = 3'b000;
        step("after reseed", 2'b11, 1'b1, 3'b001, 3'b001);
        step("first step", 2'b11, 1'b1, 3'b000, 3'b001);

        // Short mode on gen2: bit14 after the step from 0x0040 appears in bit0 fourteen steps later.
        set_freq(2, 5'd0);
        reg_noise_mode[2] = 1'b1;
        active            = 3'd7;
        reg_noise_reseed  = 3'b100;
        step("reseed2 A", 2'b11, 1'b1, 3'b100, 3'b100);
        reg_noise_reseed = 3'b000;
        for (int k = 1; k <= 24; k++) begin
            active = 3'd5;
            step($sformatf("short s%0d", k), 2'b11, 1'b1, {tbl(SHORT_TBL, k), 2'b00}, 3'b100);
        end

        // Same start, but long mode from the 10th step on: bit14 is 0 so s24 bit0 is 0.
        active           = 3'd7;
        reg_noise_reseed = 3'b100;
        step("reseed2 B", 2'b11, 1'b1, 3'b100, 3'b100);
        reg_noise_reseed = 3'b000;
        for (int k = 1; k <= 24; k++) begin
            if (k == 10) reg_noise_mode[2] = 1'b0;
            active = 3'd5;
            step($sformatf("mixed s%0d", k), 2'b11, 1'b1, {tbl(LONG_TBL, k), 2'b00}, 3'b100);
        end

        // Reset in the middle of operation.
        active = 3'd0;
        step("route before reset", 2'b01, 1'b1, 3'b000, 3'b100);
        reset  = 1'b1;
        active = 3'd5;
        step("mid reset", 2'b11, 1'b1, 3'b111, 3'b111);
        reset  = 1'b0;
        active = 3'd7;
        step("post reset idle", 2'b11, 1'b1, 3'b111, 3'b111);
        active = 3'd5;
        step("post reset tick", 2'b11, 1'b1, 3'b000, 3'b111);

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
